// File: rtl/buzzer_pkg.sv
// buzzer_pkg
//   Shared definitions for the front-panel buzzer arbiter: FSM state codes,
//   event-source indices, the per-source beep pattern lookup and the
//   fixed-priority pending-source selector.
package buzzer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_TONE = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam logic [1:0] SRC_CLICK = 2'd0;
   localparam logic [1:0] SRC_PASS  = 2'd1;
   localparam logic [1:0] SRC_ERROR = 2'd2;
   localparam logic [1:0] SRC_LOCK  = 2'd3;

   typedef struct packed {
      logic [1:0] beeps;
      logic       is_long;
   } pattern_t;

   function automatic pattern_t pattern_of(input logic [1:0] src);
      pattern_t p;
      case (src)
         SRC_CLICK: p = '{beeps: 2'd1, is_long: 1'b0};
         SRC_PASS:  p = '{beeps: 2'd2, is_long: 1'b0};
         SRC_ERROR: p = '{beeps: 2'd1, is_long: 1'b1};
         default:   p = '{beeps: 2'd3, is_long: 1'b1};
      endcase
      return p;
   endfunction

   // Highest set bit wins: lockout > error > pass > click.
   function automatic logic [1:0] top_source(input logic [3:0] pend);
      logic [1:0] s;
      s = SRC_CLICK;
      if (pend[3])      s = SRC_LOCK;
      else if (pend[2]) s = SRC_ERROR;
      else if (pend[1]) s = SRC_PASS;
      return s;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen
//   Square-wave divider for the buzzer tone. Output toggles every TONE_DIV
//   enabled cycles; a restart forces the output to 1 with the divider cleared
//   so every beep begins on a high half-period. Output is 0 while disabled.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_en       tone running this cycle
//   i_restart  synchronous restart (priority over i_en)
//   o_tone     square-wave output
module tone_gen #(
   parameter int TONE_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_restart,
   output logic o_tone
);

   localparam int            TW     = $clog2(TONE_DIV) + 1;
   localparam logic [TW-1:0] DIV_M1 = TW'(TONE_DIV - 1);

   logic [TW-1:0] r_cnt;
   logic          r_tone;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end else if (i_restart) begin
         r_cnt  <= '0;
         r_tone <= 1'b1;
      end else if (i_en) begin
         if (r_cnt == DIV_M1) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
         end else begin
            r_cnt <= r_cnt + TW'(1);
         end
      end else begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end
   end

   assign o_tone = r_tone;

endmodule

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter
//   Shares the single front-panel buzzer between the keypad-lock event
//   sources. Latches one-cycle request pulses into pending bits, grants the
//   highest-priority pending source and plays its fixed beep pattern.
//   Optional macro BUZZER_ARBITER_PREEMPT_EN: a higher-priority pending source
//   preempts a playing pattern (the preempted pattern is dropped).
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_req[3:0]   request pulses (0 click, 1 pass, 2 error, 3 lockout)
//   o_grant[3:0] one-cycle pulse for the source whose pattern starts
//   o_busy       pattern playing (TONE or GAP)
//   o_active_id  source currently playing, 0 when idle
//   o_buzzer     tone output to the pin
//
// state | meaning
// IDLE  | silent; grant highest pending source on next edge
// TONE  | beep sounding for SHORT_LEN or LONG_LEN cycles
// GAP   | silent GAP_LEN cycles between beeps of one pattern
module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter int TONE_DIV  = 50000,
   parameter int SHORT_LEN = 2500000,
   parameter int LONG_LEN  = 10000000,
   parameter int GAP_LEN   = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_req,
   output logic [3:0] o_grant,
   output logic       o_busy,
   output logic [1:0] o_active_id,
   output logic       o_buzzer
);

   localparam int MAX_SL = (SHORT_LEN > LONG_LEN) ? SHORT_LEN : LONG_LEN;
   localparam int MAXLEN = (MAX_SL > GAP_LEN) ? MAX_SL : GAP_LEN;
   localparam int CW     = $clog2(MAXLEN) + 1;

   localparam logic [CW-1:0] SHORT_M1 = CW'(SHORT_LEN - 1);
   localparam logic [CW-1:0] LONG_M1  = CW'(LONG_LEN - 1);
   localparam logic [CW-1:0] GAP_M1   = CW'(GAP_LEN - 1);

   logic [1:0]    r_state;
   logic [3:0]    r_pending;
   logic [3:0]    r_grant;
   logic [1:0]    r_active_id;
   logic [1:0]    r_beeps;
   logic          r_long;
   logic [CW-1:0] r_dur;

   logic          w_has_pend;
   logic [1:0]    w_top;
   pattern_t      w_pat;
   logic          w_tone_end;
   logic          w_gap_end;
   logic          w_preempt;
   logic          w_start;
   logic [3:0]    w_grant_vec;
   logic          w_tone_en;
   logic          w_tone_restart;

   assign w_has_pend = |r_pending;
   assign w_top      = top_source(r_pending);
   assign w_pat      = pattern_of(w_top);
   assign w_tone_end = (r_state == ST_TONE) && (r_dur == (r_long ? LONG_M1 : SHORT_M1));
   assign w_gap_end  = (r_state == ST_GAP) && (r_dur == GAP_M1);

`ifdef BUZZER_ARBITER_PREEMPT_EN
   assign w_preempt = (r_state != ST_IDLE) && w_has_pend && (w_top > r_active_id);
`else
   assign w_preempt = 1'b0;
`endif

   assign w_start = ((r_state == ST_IDLE) && w_has_pend) || w_preempt;

   always_comb begin
      w_grant_vec = '0;
      if (w_start) w_grant_vec[w_top] = 1'b1;
   end

   // Set wins over clear: a source re-requesting on its grant edge replays.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_pending   <= '0;
         r_grant     <= '0;
         r_active_id <= SRC_CLICK;
         r_beeps     <= '0;
         r_long      <= 1'b0;
         r_dur       <= '0;
      end else begin
         r_pending <= (r_pending & ~w_grant_vec) | i_req;
         r_grant   <= w_grant_vec;
         if (w_start) begin
            r_state     <= ST_TONE;
            r_active_id <= w_top;
            r_beeps     <= w_pat.beeps;
            r_long      <= w_pat.is_long;
            r_dur       <= '0;
         end else begin
            case (r_state)
               ST_TONE: begin
                  if (w_tone_end) begin
                     r_dur <= '0;
                     if (r_beeps > 2'd1) begin
                        r_state <= ST_GAP;
                     end else begin
                        r_state     <= ST_IDLE;
                        r_active_id <= SRC_CLICK;
                        r_beeps     <= '0;
                        r_long      <= 1'b0;
                     end
                  end else begin
                     r_dur <= r_dur + CW'(1);
                  end
               end
               ST_GAP: begin
                  if (w_gap_end) begin
                     r_dur   <= '0;
                     r_beeps <= r_beeps - 2'd1;
                     r_state <= ST_TONE;
                  end else begin
                     r_dur <= r_dur + CW'(1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_dur   <= '0;
               end
            endcase
         end
      end
   end

   // The divider runs only for cycles that stay in TONE after this edge.
   assign w_tone_en      = (r_state == ST_TONE) && !w_tone_end;
   assign w_tone_restart = w_start || w_gap_end;

   tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (w_tone_en),
      .i_restart (w_tone_restart),
      .o_tone    (o_buzzer)
   );

   assign o_grant     = r_grant;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_active_id = r_active_id;

endmodule
